// File: rtl/execute_mc.sv
// Y86-64 multi-cycle execute stage: valid/ready in, registered output slot,
// CC ownership, SINS flagging and an iterative shift-add multiplier.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   in_valid_i / in_ready_o   decode handshake
//   icode_i, ifun_i, stat_i   instruction code, function, incoming status
//   dstE_i                    destination register for valE
//   valA_i, valB_i, valC_i    operands
//   cc_en_i                   0 = no CC write for this instruction
//   out_valid_o / out_ready_i memory-stage handshake on the output slot
//   valE_o, dstE_o, cnd_o     slot payload
//   stat_o                    slot status
//   cc_o                      {ZF,SF,OF}
//   busy_o                    multiplier iterating
module execute_mc #(
  parameter int DATA_W = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifun_i,
  input  logic [2:0]        stat_i,
  input  logic [3:0]        dstE_i,
  input  logic [DATA_W-1:0] valA_i,
  input  logic [DATA_W-1:0] valB_i,
  input  logic [DATA_W-1:0] valC_i,
  input  logic              cc_en_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] valE_o,
  output logic [3:0]        dstE_o,
  output logic              cnd_o,
  output logic [2:0]        stat_o,
  output logic [2:0]        cc_o,
  output logic              busy_o
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_XOR = 4'd3;
  localparam logic [3:0] F_MUL = 4'd4;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] EIGHT = DATA_W'(8);
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // output slot
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] val_e_q, val_e_d;
  logic [3:0]        dst_e_q, dst_e_d;
  logic              cnd_q, cnd_d;
  logic [2:0]        stat_q, stat_d;
  logic [2:0]        cc_q, cc_d;

  // multiplier context
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        m_dst_q, m_dst_d;
  logic              m_cnd_q, m_cnd_d;
  logic              m_ccen_q, m_ccen_d;

  // decode / ALU
  logic              is_op;
  logic              stat_aok;
  logic              illegal_op;
  logic              is_mul;
  logic              mul_start;
  logic [3:0]        alu_fn;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_r;
  logic              alu_of;
  logic [2:0]        cc_new;
  logic              cc_wr_now;
  logic              cnd;
  logic [3:0]        dst_sel;
  logic [2:0]        stat_sel;

  logic              slot_free;
  logic              accept;
  logic              wr_single;
  logic              wr_mul;

  assign is_op    = (icode_i == I_OPQ);
  assign stat_aok = (stat_i == S_AOK);

  assign illegal_op = is_op &&
                      ((ifun_i > F_MUL) ||
                       ((ifun_i == F_MUL) && !MUL_EN));

  assign is_mul    = is_op && (ifun_i == F_MUL) && MUL_EN;
  assign mul_start = is_mul && stat_aok;
  assign alu_fn    = is_op ? ifun_i : F_ADD;

  always_comb begin
    alu_a = '0;
    unique case (1'b1)
      (icode_i == I_RRMOVQ),
      (icode_i == I_OPQ):    alu_a = valA_i;
      (icode_i == I_IRMOVQ),
      (icode_i == I_RMMOVQ),
      (icode_i == I_MRMOVQ): alu_a = valC_i;
      (icode_i == I_CALL),
      (icode_i == I_PUSHQ):  alu_a = '0 - EIGHT;
      (icode_i == I_RET),
      (icode_i == I_POPQ):   alu_a = EIGHT;
      default:               alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (1'b1)
      (icode_i == I_RMMOVQ),
      (icode_i == I_MRMOVQ),
      (icode_i == I_OPQ),
      (icode_i == I_CALL),
      (icode_i == I_RET),
      (icode_i == I_PUSHQ),
      (icode_i == I_POPQ): alu_b = valB_i;
      default:             alu_b = '0;
    endcase
  end

  // MUL and illegal functions fall to zero here; a legal AOK
  // multiply is produced by the iterative unit instead.
  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    unique case (alu_fn)
      F_ADD: begin
        alu_r  = alu_b + alu_a;
        alu_of = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                 (alu_r[DATA_W-1] != alu_a[DATA_W-1]);
      end
      F_SUB: begin
        alu_r  = alu_b - alu_a;
        alu_of = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                 (alu_r[DATA_W-1] != alu_b[DATA_W-1]);
      end
      F_AND: alu_r = alu_b & alu_a;
      F_XOR: alu_r = alu_b ^ alu_a;
      default: begin
        alu_r  = '0;
        alu_of = 1'b0;
      end
    endcase
  end

  assign cc_new = {(alu_r == '0), alu_r[DATA_W-1], alu_of};

  assign cc_wr_now = is_op && stat_aok && !illegal_op &&
                     !is_mul && cc_en_i;

  // condition from CC as held at accept
  always_comb begin
    cnd = 1'b0;
    unique case (ifun_i)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'd2:    cnd = cc_q[1] ^ cc_q[0];
      4'd3:    cnd = cc_q[2];
      4'd4:    cnd = !cc_q[2];
      4'd5:    cnd = !(cc_q[1] ^ cc_q[0]);
      4'd6:    cnd = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cnd = 1'b0;
    endcase
  end

  assign dst_sel = ((icode_i == I_RRMOVQ) && !cnd) ?
                   RNONE : dstE_i;

  assign stat_sel = (illegal_op && stat_aok) ? S_INS : stat_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && mul_start) state_d = MUL;
      end
      MUL: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (slot_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    slot_free  = !out_valid_q || out_ready_i;
    in_ready_o = (state_q == IDLE) && slot_free;
    busy_o     = (state_q == MUL);
    accept     = in_valid_i && in_ready_o;
    wr_single  = accept && !mul_start;
    wr_mul     = (state_q == DONE) && slot_free;
  end

  // slot, CC and multiplier datapath
  always_comb begin
    out_valid_d = out_valid_q;
    val_e_d     = val_e_q;
    dst_e_d     = dst_e_q;
    cnd_d       = cnd_q;
    stat_d      = stat_q;
    cc_d        = cc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    m_dst_d     = m_dst_q;
    m_cnd_d     = m_cnd_q;
    m_ccen_d    = m_ccen_q;

    if (wr_single) begin
      out_valid_d = 1'b1;
      val_e_d     = alu_r;
      dst_e_d     = dst_sel;
      cnd_d       = cnd;
      stat_d      = stat_sel;
      if (cc_wr_now) cc_d = cc_new;
    end else if (wr_mul) begin
      out_valid_d = 1'b1;
      val_e_d     = acc_q;
      dst_e_d     = m_dst_q;
      cnd_d       = m_cnd_q;
      stat_d      = S_AOK;
      if (m_ccen_q) begin
        cc_d = {(acc_q == '0), acc_q[DATA_W-1], 1'b0};
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (accept && mul_start) begin
      mcand_d  = alu_b;
      mplier_d = alu_a;
      acc_d    = '0;
      cnt_d    = CNT_W'(DATA_W);
      m_dst_d  = dst_sel;
      m_cnd_d  = cnd;
      m_ccen_d = cc_en_i;
    end else if (state_q == MUL) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      val_e_q     <= '0;
      dst_e_q     <= RNONE;
      cnd_q       <= 1'b0;
      stat_q      <= S_AOK;
      cc_q        <= 3'b100;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      m_dst_q     <= RNONE;
      m_cnd_q     <= 1'b0;
      m_ccen_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      val_e_q     <= val_e_d;
      dst_e_q     <= dst_e_d;
      cnd_q       <= cnd_d;
      stat_q      <= stat_d;
      cc_q        <= cc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      m_dst_q     <= m_dst_d;
      m_cnd_q     <= m_cnd_d;
      m_ccen_q    <= m_ccen_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign valE_o      = val_e_q;
  assign dstE_o      = dst_e_q;
  assign cnd_o       = cnd_q;
  assign stat_o      = stat_q;
  assign cc_o        = cc_q;

endmodule

// File: tb/tb_execute_mc.sv
// Randomized self-checking bench for execute_mc with a scoreboard
// fed by an instruction-level reference model.
module tb_execute_mc;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [3:0]    icode_i;
  logic [3:0]    ifun_i;
  logic [2:0]    stat_i;
  logic [3:0]    dstE_i;
  logic [W-1:0]  valA_i;
  logic [W-1:0]  valB_i;
  logic [W-1:0]  valC_i;
  logic          cc_en_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  valE_o;
  logic [3:0]    dstE_o;
  logic          cnd_o;
  logic [2:0]    stat_o;
  logic [2:0]    cc_o;
  logic          busy_o;

  always #5 clk = ~clk;

  execute_mc #(
    .DATA_W(W),
    .MUL_EN(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .icode_i    (icode_i),
    .ifun_i     (ifun_i),
    .stat_i     (stat_i),
    .dstE_i     (dstE_i),
    .valA_i     (valA_i),
    .valB_i     (valB_i),
    .valC_i     (valC_i),
    .cc_en_i    (cc_en_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .valE_o     (valE_o),
    .dstE_o     (dstE_o),
    .cnd_o      (cnd_o),
    .stat_o     (stat_o),
    .cc_o       (cc_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [63:0] val_e;
    logic [3:0]  dst;
    logic        cnd;
    logic [2:0]  stat;
    logic [2:0]  cc;
  } exp_t;

  exp_t        sb_q[$];
  logic [2:0]  m_cc;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] last_val_e;
  logic [3:0]  last_dst;
  logic        last_cnd;
  logic [2:0]  last_stat;
  logic        rdy_mode = 1'b0;
  logic        rdy_val = 1'b1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Instruction-level model: what the stage must deliver for one
  // accepted instruction, plus its effect on the architectural CC.
  task automatic predict(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [2:0] st, input logic [3:0] dst,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic ccen);
    exp_t e;
    logic [63:0] x, y, r;
    logic zf, sf, of, ok, legal, t;
    logic signed [64:0] wide;
    x = 0;
    y = 0;
    case (ic)
      4'h2, 4'h6:       x = a;
      4'h3, 4'h4, 4'h5: x = c;
      4'h8, 4'hA:       x = -64'sd8;
      4'h9, 4'hB:       x = 64'd8;
      default:          x = 0;
    endcase
    case (ic)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: y = b;
      default: y = 0;
    endcase
    zf = m_cc[2];
    sf = m_cc[1];
    of = m_cc[0];
    case (fn)
      4'd0:    t = 1;
      4'd1:    t = (sf != of) || zf;
      4'd2:    t = (sf != of);
      4'd3:    t = zf;
      4'd4:    t = !zf;
      4'd5:    t = (sf == of);
      4'd6:    t = (sf == of) && !zf;
      default: t = 0;
    endcase
    ok = (st == 3'd1);
    legal = !(ic == 4'h6 && fn > 4);
    r = 0;
    wide = 0;
    if (ic != 4'h6) r = y + x;
    else begin
      case (fn)
        4'd0: begin
          r = y + x;
          wide = $signed({y[63], y}) + $signed({x[63], x});
        end
        4'd1: begin
          r = y - x;
          wide = $signed({y[63], y}) - $signed({x[63], x});
        end
        4'd2: r = y & x;
        4'd3: r = y ^ x;
        4'd4: r = ok ? y * x : 64'd0;
        default: r = 0;
      endcase
    end
    e.val_e = r;
    e.cnd = t;
    e.dst = (ic == 4'h2 && !t) ? 4'hF : dst;
    e.stat = (ic == 4'h6 && !legal && ok) ? 3'd4 : st;
    if (ic == 4'h6 && ok && legal && ccen) begin
      // signed overflow: the true sum does not fit in 64 bits
      of = (fn <= 1) ? (wide[64] != wide[63]) : 1'b0;
      m_cc = {r == 0, r[63], of};
    end
    e.cc = m_cc;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every slot handover is compared with the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n_i && out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", {63'b0, out_valid_o}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("valE", valE_o, e.val_e);
          check("dstE", {60'b0, dstE_o}, {60'b0, e.dst});
          check("cnd", {63'b0, cnd_o}, {63'b0, e.cnd});
          check("stat", {61'b0, stat_o}, {61'b0, e.stat});
          check("cc", {61'b0, cc_o}, {61'b0, e.cc});
          last_val_e = valE_o;
          last_dst   = dstE_o;
          last_cnd   = cnd_o;
          last_stat  = stat_o;
        end
      end
    end
  end

  // out_ready driver: fixed level or random back-pressure
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready_i = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [2:0] st, input logic [3:0] dst,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic ccen);
    int  n;
    logic acc;
    icode_i = ic;
    ifun_i = fn;
    stat_i = st;
    dstE_i = dst;
    valA_i = a;
    valB_i = b;
    valC_i = c;
    cc_en_i = ccen;
    in_valid_i = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      #2;
      acc = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    if (!acc) check("accept_timeout", {63'b0, in_ready_o}, 64'd1);
    else predict(ic, fn, st, dst, a, b, c, ccen);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0:       return 64'($urandom_range(0, 15));
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int k, nb, bad;
    logic [3:0] ic, fn;
    logic [2:0] st;

    rst_n_i = 1'b0;
    in_valid_i = 1'b0;
    icode_i = 0;
    ifun_i = 0;
    stat_i = 3'd1;
    dstE_i = 0;
    valA_i = 0;
    valB_i = 0;
    valC_i = 0;
    cc_en_i = 1'b1;
    m_cc = 3'b100;
    repeat (3) @(posedge clk);
    #1 rst_n_i = 1'b1;
    tick();

    check("rst_cc", {61'b0, cc_o}, 64'b100);
    check("rst_stat", {61'b0, stat_o}, 64'd1);
    check("rst_dst", {60'b0, dstE_o}, 64'hF);
    check("rst_ovalid", {63'b0, out_valid_o}, 64'd0);
    check("rst_iready", {63'b0, in_ready_o}, 64'd1);
    check("rst_valE", valE_o, 64'd0);
    check("rst_cnd", {63'b0, cnd_o}, 64'd0);
    check("rst_busy", {63'b0, busy_o}, 64'd0);

    // ADD 1+2 leaves CC=000, then SUB 5-5 sets ZF
    send(4'h6, 4'd0, 3'd1, 4'd3, 64'd1, 64'd2, 0, 1'b1);
    check("add_cc", {61'b0, cc_o}, 64'b000);
    send(4'h6, 4'd1, 3'd1, 4'd3, 64'd5, 64'd5, 0, 1'b1);
    check("sub_cc_at_accept", {61'b0, cc_o}, 64'b100);
    send(4'h7, 4'd3, 3'd1, 4'hF, 0, 0, 0, 1'b1);
    drain();
    check("je_cnd", {63'b0, last_cnd}, 64'd1);

    // signed overflow on ADD
    send(4'h6, 4'd0, 3'd1, 4'd4, 64'h7FFF_FFFF_FFFF_FFFF,
         64'd1, 0, 1'b1);
    check("ovf_cc", {61'b0, cc_o}, 64'b011);
    drain();
    check("ovf_valE", last_val_e, 64'h8000_0000_0000_0000);
    send(4'h6, 4'd1, 3'd1, 4'd3, 64'd5, 64'd5, 0, 1'b1);
    send(4'h6, 4'd0, 3'd1, 4'd4, 64'h7FFF_FFFF_FFFF_FFFF,
         64'd1, 0, 1'b0);
    drain();
    check("noccen_valE", last_val_e, 64'h8000_0000_0000_0000);
    check("noccen_cc", {61'b0, cc_o}, 64'b100);

    // CC=000: cmovl not taken, push, illegal OPQ
    send(4'h6, 4'd0, 3'd1, 4'd3, 64'd1, 64'd1, 0, 1'b1);
    send(4'h2, 4'd2, 3'd1, 4'd5, 64'd9, 0, 0, 1'b1);
    drain();
    check("cmov_dst", {60'b0, last_dst}, 64'hF);
    check("cmov_valE", last_val_e, 64'd9);
    send(4'hA, 4'd0, 3'd1, 4'd4, 0, 64'h100, 0, 1'b1);
    drain();
    check("push_valE", last_val_e, 64'hF8);
    send(4'h6, 4'd7, 3'd1, 4'd2, 64'd3, 64'd4, 0, 1'b1);
    drain();
    check("ins_stat", {61'b0, last_stat}, 64'd4);
    check("ins_cc", {61'b0, cc_o}, 64'b000);

    // MUL latency, busy window, in_ready held low
    send(4'h6, 4'd4, 3'd1, 4'd2, 64'd7, 64'd6, 0, 1'b1);
    k = 0;
    nb = 0;
    bad = 0;
    while (!out_valid_o && k < 200) begin
      if (busy_o) nb++;
      if (in_ready_o) bad++;
      tick();
      k++;
    end
    check("mul_latency", k, 65);
    check("mul_busy_cycles", nb, 64);
    check("mul_iready_low", bad, 0);
    drain();
    check("mul_valE", last_val_e, 64'd42);

    // result written with no taker is held stable
    rdy_val = 1'b0;
    send(4'h6, 4'd4, 3'd1, 4'd1, 64'd3, 64'd5, 0, 1'b1);
    k = 0;
    while (!out_valid_o && k < 200) begin
      tick();
      k++;
    end
    check("stall_latency", k, 65);
    bad = 0;
    repeat (10) begin
      tick();
      if (!out_valid_o || valE_o != 64'd15 || in_ready_o) bad++;
    end
    check("stall_stable", bad, 0);
    rdy_val = 1'b1;
    drain();

    // reset in the middle of a multiply
    send(4'h6, 4'd0, 3'd1, 4'd3, 64'd1, 64'd1, 0, 1'b1);
    send(4'h6, 4'd4, 3'd1, 4'd1, 64'd9, 64'd9, 0, 1'b1);
    repeat (20) tick();
    rst_n_i = 1'b0;
    #1;
    check("midrst_cc", {61'b0, cc_o}, 64'b100);
    check("midrst_busy", {63'b0, busy_o}, 64'd0);
    check("midrst_ovalid", {63'b0, out_valid_o}, 64'd0);
    sb_q.delete();
    m_cc = 3'b100;
    tick();
    rst_n_i = 1'b1;
    bad = 0;
    repeat (80) begin
      tick();
      if (out_valid_o || busy_o) bad++;
    end
    check("midrst_quiet", bad, 0);

    // random traffic with random back-pressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) tick();
      st = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 11));
      if (ic == 4'h6)
        fn = (st == 3'd1) ? 4'($urandom_range(0, 7))
                          : 4'($urandom_range(0, 4));
      else
        fn = 4'($urandom_range(0, 15));
      send(ic, fn, st, 4'($urandom_range(0, 15)),
           rnd64(), rnd64(), rnd64(), ($urandom_range(0, 4) != 0));
    end
    rdy_mode = 1'b0;
    rdy_val = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
